// File: rtl/t5_pkg.sv
// t5_pkg: shared defaults and helpers for the t5 hart fetch unit.
// Provides the default hart count, reset PC and hart-tag width function.
package t5_pkg;

    localparam int          HARTS_DEF    = 4;
    localparam logic [29:0] RESET_PC_DEF = 30'h0;

    // Width of a hart tag; never narrower than one bit.
    function automatic int hw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/t5_rrarb.sv
// t5_rrarb: round-robin picker over a request vector.
// Ports: req (requests), last (previous grant) -> gnt (index), gvld.
module t5_rrarb
    import t5_pkg::*;
#(
    parameter  int N = HARTS_DEF,
    localparam int W = hw_of(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] gnt,
    output logic         gvld
);

    // Scan from the farthest candidate back to the nearest so the
    // nearest requester after 'last' is the one left in gnt. The
    // candidate i=N wraps onto 'last' itself (lowest priority).
    always_comb begin
        logic [W-1:0] idx;
        gnt  = last;
        gvld = 1'b0;
        idx  = last;
        for (int i = N; i >= 1; i--) begin
            idx = last + W'(i);
            if (req[idx]) begin
                gnt  = idx;
                gvld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t5_hfet.sv
// t5_hfet: barrel-threaded fetch stage with per-hart PCs and F/D/X/M tags.
// Ports: sclk/srst, sena advance, hena/hpark/hwake per hart, xbra/xbpc
// redirect from X, iwb_* instruction bus, fpc/fhart and stage tags/valids.
// Build option: T5_HFET_PARK_EN enables the per-hart park bits.
module t5_hfet
    import t5_pkg::*;
#(
    parameter  int          HARTS    = HARTS_DEF,
    parameter  logic [29:0] RESET_PC = RESET_PC_DEF,
    localparam int          HW       = hw_of(HARTS)
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             sena,
    input  logic [HARTS-1:0] hena,
    input  logic [HARTS-1:0] hpark,
    input  logic [HARTS-1:0] hwake,
    input  logic             xbra,
    input  logic [31:2]      xbpc,
    input  logic             iwb_ack,
    output logic [31:2]      iwb_adr,
    output logic             iwb_stb,
    output logic             iwb_wre,
    output logic [3:0]       iwb_sel,
    output logic [31:2]      fpc,
    output logic [HW-1:0]    fhart,
    output logic [HW-1:0]    dhart,
    output logic [HW-1:0]    xhart,
    output logic [HW-1:0]    mhart,
    output logic             fvld,
    output logic             dvld,
    output logic             xvld,
    output logic             mvld
);

    logic             adv;
    logic             redir;
    logic [HARTS-1:0] parked;
    logic [HARTS-1:0] busy;
    logic [HARTS-1:0] x_leave;
    logic [HARTS-1:0] elig;
    logic [HW-1:0]    last;
    logic [HW-1:0]    gnt;
    logic             gvld;
    logic [29:0]      nxt_pc;
    logic [29:0]      pc [HARTS];

    assign iwb_stb = fvld;
    assign iwb_adr = fpc;
    assign iwb_wre = 1'b0;
    assign iwb_sel = 4'hF;

    // The hart in X moves to M on this advance, so it may reissue now;
    // that keeps a lone hart at one issue every three cycles.
    always_comb begin
        adv   = sena & (~fvld | iwb_ack);
        redir = adv & xbra & xvld;
        for (int h = 0; h < HARTS; h++) begin
            x_leave[h] = xvld && (xhart == HW'(h));
        end
        elig = hena & ~parked & ~(busy & ~x_leave);
        // A hart leaving X can be reissued while being redirected.
        nxt_pc = (redir && (xhart == gnt)) ? xbpc : pc[gnt];
    end

    t5_rrarb #(.N(HARTS)) u_arb (
        .req  (elig),
        .last (last),
        .gnt  (gnt),
        .gvld (gvld)
    );

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            fvld  <= 1'b0;
            dvld  <= 1'b0;
            xvld  <= 1'b0;
            mvld  <= 1'b0;
            fhart <= '0;
            dhart <= '0;
            xhart <= '0;
            mhart <= '0;
            fpc   <= RESET_PC;
            last  <= HW'(HARTS - 1);
            busy  <= '0;
            for (int h = 0; h < HARTS; h++) begin
                pc[h] <= RESET_PC;
            end
        end else if (adv) begin
            fvld <= gvld;
            if (gvld) begin
                fhart <= gnt;
                fpc   <= nxt_pc;
                last  <= gnt;
            end
            dvld  <= fvld;
            dhart <= fhart;
            xvld  <= dvld;
            xhart <= dhart;
            mvld  <= xvld;
            mhart <= xhart;
            for (int h = 0; h < HARTS; h++) begin
                if (gvld && (gnt == HW'(h))) begin
                    pc[h]   <= nxt_pc + 30'd1;
                    busy[h] <= 1'b1;
                end else begin
                    if (redir && (xhart == HW'(h))) begin
                        pc[h] <= xbpc;
                    end
                    if (x_leave[h]) begin
                        busy[h] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef T5_HFET_PARK_EN
    // Wake has priority over a simultaneous park request.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            parked <= '0;
        end else begin
            parked <= (parked | hpark) & ~hwake;
        end
    end
`else
    logic park_unused;
    assign parked      = '0;
    assign park_unused = ^{hpark, hwake};
`endif

endmodule

// File: tb/tb_t5_hfet.sv
// tb_t5_hfet: directed and randomized bench for t5_hfet.
// Reference model tracks in-flight slots per stage and per-hart PCs.
module tb_t5_hfet;

    localparam int H = 4;

    logic         sclk = 1'b0;
    logic         srst;
    logic         sena;
    logic [H-1:0] hena;
    logic [H-1:0] hpark;
    logic [H-1:0] hwake;
    logic         xbra;
    logic [31:2]  xbpc;
    logic         iwb_ack;
    logic [31:2]  iwb_adr;
    logic         iwb_stb;
    logic         iwb_wre;
    logic [3:0]   iwb_sel;
    logic [31:2]  fpc;
    logic [1:0]   fhart;
    logic [1:0]   dhart;
    logic [1:0]   xhart;
    logic [1:0]   mhart;
    logic         fvld;
    logic         dvld;
    logic         xvld;
    logic         mvld;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit        v;
        int        h;
        bit [29:0] pc;
    } slot_t;

    slot_t     mf, md, mx, mm;
    bit [29:0] mpc [H];
    int        mlast;
    bit [H-1:0] mpark;

    t5_hfet dut (
        .sclk    (sclk),
        .srst    (srst),
        .sena    (sena),
        .hena    (hena),
        .hpark   (hpark),
        .hwake   (hwake),
        .xbra    (xbra),
        .xbpc    (xbpc),
        .iwb_ack (iwb_ack),
        .iwb_adr (iwb_adr),
        .iwb_stb (iwb_stb),
        .iwb_wre (iwb_wre),
        .iwb_sel (iwb_sel),
        .fpc     (fpc),
        .fhart   (fhart),
        .dhart   (dhart),
        .xhart   (xhart),
        .mhart   (mhart),
        .fvld    (fvld),
        .dvld    (dvld),
        .xvld    (xvld),
        .mvld    (mvld)
    );

    always #5 sclk = ~sclk;

    function automatic void model_reset();
        mf = '{1'b0, 0, 30'h0};
        md = '{1'b0, 0, 30'h0};
        mx = '{1'b0, 0, 30'h0};
        mm = '{1'b0, 0, 30'h0};
        for (int h = 0; h < H; h++) mpc[h] = 30'h0;
        mlast = H - 1;
        mpark = '0;
    endfunction

    // A hart may issue if nothing of it would remain in F..X after the
    // shift: i.e. it is not in F or D now (X moves on to M).
    function automatic void model_step();
        bit adv;
        int pick;
        adv = sena && (!mf.v || iwb_ack);
        if (adv) begin
            if (xbra && mx.v) mpc[mx.h] = xbpc;
            pick = -1;
            for (int k = 1; k <= H; k++) begin
                int h;
                h = (mlast + k) % H;
                if (pick < 0 && hena[h] && !mpark[h] &&
                    !(mf.v && mf.h == h) && !(md.v && md.h == h))
                    pick = h;
            end
            mm = mx;
            mx = md;
            md = mf;
            if (pick >= 0) begin
                mf = '{1'b1, pick, mpc[pick]};
                mpc[pick] = mpc[pick] + 30'd1;
                mlast = pick;
            end else begin
                mf.v = 1'b0;
            end
        end
`ifdef T5_HFET_PARK_EN
        mpark = (mpark | hpark) & ~hwake;
`endif
    endfunction

    task automatic step();
        model_step();
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        int        exp_h  [5] = '{0, 1, 2, 3, 0};
        bit [29:0] exp_pc [5] = '{30'h0, 30'h0, 30'h0, 30'h0, 30'h1};
        srst = 1'b0;
        model_reset();
        #12;
        n_chk++;
        if ({iwb_stb, fvld, dvld, xvld, mvld} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b required 00000",
                     {iwb_stb, fvld, dvld, xvld, mvld});
        end
        n_chk++;
        if ({fhart, dhart, xhart, mhart} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_tags: got %h required 00",
                     {fhart, dhart, xhart, mhart});
        end
        n_chk++;
        if (iwb_wre !== 1'b0 || iwb_sel !== 4'hF) begin
            n_fail++;
            $display("FAIL bus_const: wre=%b sel=%h required 0/f",
                     iwb_wre, iwb_sel);
        end
        srst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (fvld !== 1'b1 || fhart !== 2'(exp_h[i]) ||
                fpc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL reset_seq[%0d]: v=%b h=%0d pc=%h required 1/%0d/%h",
                         i, fvld, fhart, fpc, exp_h[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall();
        iwb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (iwb_stb !== 1'b1 || iwb_adr !== 30'h1 || fhart !== 2'd0 ||
                dhart !== 2'd3 || xhart !== 2'd2 || mhart !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: stb=%b adr=%h f%0d d%0d x%0d m%0d required 1/1 f0 d3 x2 m1",
                         i, iwb_stb, iwb_adr, fhart, dhart, xhart, mhart);
            end
        end
        iwb_ack = 1'b1;
        step();
        n_chk++;
        if (fhart !== 2'd1 || fpc !== 30'h1 || dhart !== 2'd0 ||
            xhart !== 2'd3 || mhart !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_release: f%0d pc=%h d%0d x%0d m%0d required f1 pc=1 d0 x3 m2",
                     fhart, fpc, dhart, xhart, mhart);
        end
    endtask

    task automatic test_redirect();
        int guard = 0;
        while (!(mx.v && mx.h == 2) && guard < 20) begin
            step();
            guard++;
        end
        n_chk++;
        if (guard >= 20 || xvld !== 1'b1 || xhart !== 2'd2) begin
            n_fail++;
            $display("FAIL redirect_setup: xvld=%b xhart=%0d required 1/2",
                     xvld, xhart);
        end
        xbra = 1'b1;
        xbpc = 30'h100;
        step();
        xbra = 1'b0;
        xbpc = '0;
        guard = 0;
        while (!(fvld === 1'b1 && fhart === 2'd2) && guard < 20) begin
            step();
            guard++;
        end
        n_chk++;
        if (guard >= 20 || fpc !== 30'h100) begin
            n_fail++;
            $display("FAIL redirect_pc: fpc=%h wait=%0d required 100",
                     fpc, guard);
        end
    endtask

    task automatic test_park();
        int seen1 = 0;
        int prev  = -1;
        int rj    = -1;
        hpark = 4'b0010;
        step();
        hpark = '0;
        if (fvld === 1'b1) prev = int'(fhart);
        for (int i = 0; i < 8; i++) begin
            step();
            if (fvld === 1'b1 && fhart === 2'd1) seen1++;
            if (fvld === 1'b1) prev = int'(fhart);
            n_chk++;
            if (fvld !== mf.v || (mf.v && fhart !== 2'(mf.h))) begin
                n_fail++;
                $display("FAIL park_model[%0d]: v=%b h=%0d required %b/%0d",
                         i, fvld, fhart, mf.v, mf.h);
            end
        end
`ifdef T5_HFET_PARK_EN
        n_chk++;
        if (seen1 != 0) begin
            n_fail++;
            $display("FAIL park_skip: hart1 issued %0d times required 0", seen1);
        end
        hwake = 4'b0010;
        step();
        hwake = '0;
        if (fvld === 1'b1 && fhart === 2'd1) rj = prev;
        if (fvld === 1'b1) prev = int'(fhart);
        for (int i = 0; i < 8 && rj < 0; i++) begin
            step();
            if (fvld === 1'b1 && fhart === 2'd1) rj = prev;
            if (fvld === 1'b1) prev = int'(fhart);
        end
        n_chk++;
        if (rj != 0) begin
            n_fail++;
            $display("FAIL park_rejoin: hart1 after hart %0d required 0", rj);
        end
        hpark = 4'b0010;
        hwake = 4'b0010;
        step();
        hpark = '0;
        hwake = '0;
        seen1 = 0;
`else
        n_chk++;
        if (seen1 == 0) begin
            n_fail++;
            $display("FAIL park_disabled: hart1 issued %0d times required >0", seen1);
        end
        seen1 = 0;
`endif
        for (int i = 0; i < 8; i++) begin
            step();
            if (fvld === 1'b1 && fhart === 2'd1) seen1++;
        end
        n_chk++;
        if (seen1 == 0) begin
            n_fail++;
            $display("FAIL park_wake_wins: hart1 issued %0d times required >0", seen1);
        end
    endtask

    task automatic test_single();
        int cnt  = 0;
        int last = -1;
        hena = 4'b0001;
        for (int i = 0; i < 6; i++) step();
        for (int i = 0; i < 9; i++) begin
            step();
            n_chk++;
            if (fvld !== mf.v || (fvld === 1'b1 && fhart !== 2'd0)) begin
                n_fail++;
                $display("FAIL single_model[%0d]: v=%b h=%0d required %b/0",
                         i, fvld, fhart, mf.v);
            end
            if (fvld === 1'b1) begin
                if (last >= 0) begin
                    n_chk++;
                    if (i - last != 3) begin
                        n_fail++;
                        $display("FAIL single_gap: gap=%0d required 3", i - last);
                    end
                end
                last = i;
                cnt++;
            end
        end
        n_chk++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL single_count: issues=%0d required 3", cnt);
        end
        hena = 4'hF;
    endtask

    task automatic test_reset_mid();
        int        exp_h  [5] = '{0, 1, 2, 3, 0};
        bit [29:0] exp_pc [5] = '{30'h0, 30'h0, 30'h0, 30'h0, 30'h1};
        for (int i = 0; i < 4; i++) step();
        iwb_ack = 1'b0;
        step();
        n_chk++;
        if (iwb_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefetch: stb=%b required 1", iwb_stb);
        end
        #2;
        srst = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (iwb_stb !== 1'b0 || fvld !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_stb: stb=%b fvld=%b required 0/0",
                     iwb_stb, fvld);
        end
        iwb_ack = 1'b1;
        @(posedge sclk);
        #1;
        srst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (fvld !== 1'b1 || fhart !== 2'(exp_h[i]) ||
                fpc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL mid_seq[%0d]: v=%b h=%0d pc=%h required 1/%0d/%h",
                         i, fvld, fhart, fpc, exp_h[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sena    = ($urandom_range(0, 9) != 0);
            iwb_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) hena = 4'($urandom);
            xbra  = ($urandom_range(0, 3) == 0);
            xbpc  = 30'($urandom);
            hpark = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            hwake = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            step();
            n_chk++;
            if ({fvld, dvld, xvld, mvld} !== {mf.v, md.v, mx.v, mm.v}) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d]: got %b required %b", i,
                         {fvld, dvld, xvld, mvld}, {mf.v, md.v, mx.v, mm.v});
            end
            if (mf.v) begin
                n_chk++;
                if (fhart !== 2'(mf.h) || fpc !== mf.pc ||
                    iwb_adr !== mf.pc || iwb_stb !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_fetch[%0d]: h=%0d pc=%h adr=%h stb=%b required %0d/%h",
                             i, fhart, fpc, iwb_adr, iwb_stb, mf.h, mf.pc);
                end
            end
            if (mx.v) begin
                n_chk++;
                if (xhart !== 2'(mx.h) || (md.v && dhart !== 2'(md.h))) begin
                    n_fail++;
                    $display("FAIL rnd_tags[%0d]: d=%0d x=%0d required %0d/%0d",
                             i, dhart, xhart, md.h, mx.h);
                end
            end
        end
        sena  = 1'b1;
        xbra  = 1'b0;
        hpark = '0;
        hwake = '0;
    endtask

    initial begin
        srst    = 1'b0;
        sena    = 1'b1;
        hena    = 4'hF;
        hpark   = '0;
        hwake   = '0;
        xbra    = 1'b0;
        xbpc    = '0;
        iwb_ack = 1'b1;
        model_reset();
        test_reset();
        test_stall();
        test_redirect();
        test_park();
        test_single();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/t5_hfet.md
T5_HFET -- requirements
Module: t5_hfet

Interface
REQ-001 SHALL have parameter HARTS, default 4, meaning the number of hardware threads (power of 2, 2..16); HW = log2(HARTS).
REQ-002 SHALL have parameter RESET_PC, default 30'h0, meaning the word-address start PC of every hart.
REQ-003 SHALL have port sclk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port srst, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have port sena, input, 1, meaning the global pipeline advance enable.
REQ-006 SHALL have port hena, input, HARTS, meaning the per-hart run enable.
REQ-007 SHALL have port hpark, input, HARTS, meaning the per-hart park request (data-bus wait).
REQ-008 SHALL have port hwake, input, HARTS, meaning the per-hart wake.
REQ-009 SHALL have port xbra, input, 1, meaning the redirect for the hart currently in X.
REQ-010 SHALL have port xbpc, input, [31:2], meaning the redirect target.
REQ-011 SHALL have port iwb_ack, input, 1, meaning the instruction bus acknowledge.
REQ-012 SHALL have ports iwb_adr, output, [31:2]; iwb_stb, output, 1; iwb_wre, output, 1; and iwb_sel, output, 4, meaning the instruction bus.
REQ-013 SHALL have ports fpc, output, [31:2], and fhart, output, HW, meaning the PC and hart tag of the F-stage fetch.
REQ-014 SHALL have ports dhart, xhart and mhart, outputs, HW each, meaning the stage hart tags.
REQ-015 SHALL have ports fvld, dvld, xvld and mvld, outputs, 1 each, meaning the stage valids.

Function
REQ-016 SHALL compute adv = sena & (~fvld | iwb_ack); all pipeline and PC state changes occur only when adv=1, except park/wake bits.
REQ-017 SHALL define eligible[h] = hena[h] & ~parked[h] & ~busy[h]; busy[h] is set on issue and cleared when h leaves X.
REQ-018 SHALL, on adv, select the first eligible hart strictly after the last-issued hart (round-robin, wrapping HARTS-1 to 0), load F with fpc=pc[h], fhart=h, fvld=1, and set pc[h] <= pc[h]+1 (mod 2^30).
REQ-019 SHALL, when no hart is eligible, inject a bubble: fvld=0, pointer unchanged.
REQ-020 SHALL shift F->D->X->M (tag and valid) on adv.
REQ-021 SHALL drive iwb_stb=fvld and iwb_adr=fpc, and hold both stable until iwb_ack; iwb_wre=0 and iwb_sel=4'hF are constant.
REQ-022 SHALL, when xbra & xvld & adv, write pc[xhart] <= xbpc; an issue of a different hart in the same cycle is also applied.
REQ-023 SHALL guarantee that at most one instruction per hart exists in F..X, so a redirect never requires a flush.
REQ-024 SHALL set parked[h] on hpark[h] and clear it on hwake[h], independent of adv; when both are asserted, wake wins.
REQ-025 SHALL let an instruction already in flight for a newly parked hart continue; parking blocks new issue only.
REQ-026 SHALL stop issuing to a hart when its hena drops, retaining its pc and letting in-flight instructions drain.

Reset
REQ-027 SHALL, while srst=0, force pc[all]=RESET_PC, parked=0, busy=0, all valids=0, all tags=0, iwb_stb=0 and pointer=HARTS-1, so the first issue after reset is to hart 0.
REQ-028 SHALL drop iwb_stb immediately on reset assertion mid-fetch; a late iwb_ack after release SHALL be ignored while fvld=0.

Configuration
REQ-029 SHALL, with T5_HFET_PARK_EN defined, implement the parked bits as specified.
REQ-030 SHALL, without T5_HFET_PARK_EN, tie parked to 0 and leave hpark/hwake unused, ports retained.

Structure
REQ-031 SHALL take HARTS default, RESET_PC default and the hart-tag width function from shared package t5_pkg.
REQ-032 SHALL implement round-robin selection in sub-module t5_rrarb (request vector, last pointer in; grant index and valid out).

Verification
REQ-033 SHALL test reset release with HARTS=4, all hena=1, sena=1 and iwb_ack=1 -> fhart sequence 0,1,2,3,0 with fpc=0,0,0,0,1.
REQ-034 SHALL test holding iwb_ack=0 for 3 cycles -> iwb_adr, iwb_stb, fhart and all stage tags frozen for 3 cycles, then advancing.
REQ-035 SHALL test hart 2 in X with xbra=1 and xbpc=30'h100 -> the next hart-2 issue has fpc=30'h100.
REQ-036 SHALL test hpark[1] pulsed -> hart 1 skipped (0,2,3,0,...), and after hwake[1] it rejoins in round-robin order; simultaneous hpark[1]/hwake[1] -> not parked.
REQ-037 SHALL test hena=4'b0001 with HARTS=4 -> hart 0 issues only once every 3 cycles (busy through X) with bubbles between.
REQ-038 SHALL test srst asserted mid-fetch -> iwb_stb=0 immediately, and the post-release sequence is identical to REQ-033.
